dbg_uart_bridge: RTL and testbench

DBG_UART_BRIDGE -- requirements
Module: dbg_uart_bridge

---
 rtl/dbg_uart_bridge_if.sv | 25 ++
 rtl/dbg_uart_bridge.sv | 150 +++++++++++++++
 tb/tb_dbg_uart_bridge.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_uart_bridge_if.sv
// Signal bundle between the debug UART bridge and its surroundings:
// UART byte stream, CPU reset and the SoC debug memory port.
interface dbg_uart_bridge_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        cpu_n_reset;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [31:0] dbg_di;

    modport master (
        input  rx_data, rx_valid, tx_busy, dbg_di,
        output tx_data, tx_start, cpu_n_reset, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, dbg_di,
        input  tx_data, tx_start, cpu_n_reset, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
    );
endinterface

// File: rtl/dbg_uart_bridge.sv
// Host-side debug bridge: parses a UART command stream (W/R/H/G) and drives
// the SoC debug memory port and CPU reset, answering over the UART transmitter.
module dbg_uart_bridge #(
    parameter int unsigned MEM_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 2000000,
    parameter bit          BOOT_HOLD  = 1'b1
) (
    input  logic              clk,
    input  logic              n_reset,
    dbg_uart_bridge_if.master bus
);
    localparam logic [7:0]  CMD_W     = 8'h57;
    localparam logic [7:0]  CMD_R     = 8'h52;
    localparam logic [7:0]  CMD_H     = 8'h48;
    localparam logic [7:0]  CMD_G     = 8'h47;
    localparam logic [7:0]  RSP_OK    = 8'h4B;
    localparam logic [7:0]  RSP_ERR   = 8'h3F;
    localparam logic [3:0]  MEM_LAST  = 4'(MEM_CYCLES - 1);
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM, RESP} state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [3:0]  mem_cnt;
    logic [31:0] idle_cnt;
    logic        is_write;
    logic [31:0] resp_sh;
    logic [2:0]  resp_left;
    logic [31:0] adr_sh;
    logic [31:0] data_sh;
    logic [31:0] adr_next;
    logic [31:0] data_next;

    // Operands arrive LSB first, so each byte enters at the top and shifts down.
    assign adr_next  = {bus.rx_data, adr_sh[31:8]};
    assign data_next = {bus.rx_data, data_sh[31:8]};

    always_ff @(posedge clk) begin
        if (bus.rx_valid && state == ADDR) adr_sh  <= adr_next;
        if (bus.rx_valid && state == DATA) data_sh <= data_next;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state           <= IDLE;
            byte_cnt        <= 2'd0;
            mem_cnt         <= 4'd0;
            idle_cnt        <= 32'd0;
            is_write        <= 1'b0;
            resp_sh         <= 32'd0;
            resp_left       <= 3'd0;
            bus.tx_start    <= 1'b0;
            bus.tx_data     <= 8'd0;
            bus.dbg_mem_op  <= 1'b0;
            bus.dbg_wren    <= 4'h0;
            bus.dbg_adr     <= 32'd0;
            bus.dbg_do      <= 32'd0;
            bus.cpu_n_reset <= !BOOT_HOLD;
        end else begin
            bus.tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        byte_cnt <= 2'd0;
                        idle_cnt <= 32'd0;
                        case (bus.rx_data)
                            CMD_W: begin
                                is_write <= 1'b1;
                                state    <= ADDR;
                            end
                            CMD_R: begin
                                is_write <= 1'b0;
                                state    <= ADDR;
                            end
                            CMD_H: begin
                                bus.cpu_n_reset <= 1'b0;
                                resp_sh         <= {24'd0, RSP_OK};
                                resp_left       <= 3'd1;
                                state           <= RESP;
                            end
                            CMD_G: begin
                                bus.cpu_n_reset <= 1'b1;
                                resp_sh         <= {24'd0, RSP_OK};
                                resp_left       <= 3'd1;
                                state           <= RESP;
                            end
                            default: begin
                                resp_sh   <= {24'd0, RSP_ERR};
                                resp_left <= 3'd1;
                                state     <= RESP;
                            end
                        endcase
                    end
                end
                ADDR, DATA: begin
                    // A byte arriving in the expiry clock wins over the timeout.
                    if (bus.rx_valid) begin
                        idle_cnt <= 32'd0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (state == ADDR && is_write) begin
                                state <= DATA;
                            end else begin
                                state          <= MEM;
                                mem_cnt        <= 4'd0;
                                bus.dbg_mem_op <= 1'b1;
                                bus.dbg_wren   <= is_write ? 4'hF : 4'h0;
                                bus.dbg_adr    <= (state == ADDR) ? adr_next : adr_sh;
                                if (is_write) bus.dbg_do <= data_next;
                            end
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        idle_cnt <= 32'd0;
                        state    <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                MEM: begin
                    if (mem_cnt == MEM_LAST) begin
                        bus.dbg_mem_op <= 1'b0;
                        bus.dbg_wren   <= 4'h0;
                        state          <= RESP;
                        if (is_write) begin
                            resp_sh   <= {24'd0, RSP_OK};
                            resp_left <= 3'd1;
                        end else begin
                            resp_sh   <= bus.dbg_di;
                            resp_left <= 3'd4;
                        end
                    end else begin
                        mem_cnt <= mem_cnt + 4'd1;
                    end
                end
                RESP: begin
                    // tx_start still high means the previous byte left only this clock.
                    if (!bus.tx_busy && !bus.tx_start) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= resp_sh[7:0];
                        resp_sh      <= {8'd0, resp_sh[31:8]};
                        resp_left    <= resp_left - 3'd1;
                        if (resp_left == 3'd1) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_uart_bridge.sv
// Scoreboard bench for dbg_uart_bridge: a command-level model queues expected
// bus cycles and response bytes; a monitor checks what the bridge presents.
module tb_dbg_uart_bridge;
    localparam int MEM_CYCLES = 2;
    localparam int TIMEOUT    = 100;

    typedef struct packed {
        logic        wr;
        logic [31:0] adr;
        logic [31:0] data;
    } mem_op_t;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    dbg_uart_bridge_if bus ();

    dbg_uart_bridge #(
        .MEM_CYCLES(MEM_CYCLES),
        .TIMEOUT   (TIMEOUT),
        .BOOT_HOLD (1'b1)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (bus)
    );

    mem_op_t     mem_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  cmd[9];
    logic [31:0] rd_data;
    logic [31:0] model_do;
    logic        exp_cpu;
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          tx_count = 0;
    int          mem_count = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running after 100000 cycles, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // UART transmitter stand-in: busy rises the clock after a start, for a random length.
    initial begin : transmitter
        int busy_len;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (n_reset && bus.tx_start) begin
                busy_len = $urandom_range(0, 5);
                if (busy_len > 0) begin
                    @(posedge clk);
                    #1 bus.tx_busy = 1'b1;
                    repeat (busy_len) @(posedge clk);
                    #1 bus.tx_busy = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        mem_op_t     cur;
        bit          in_mem;
        int          mem_len;
        int          last_tx;
        logic [31:0] last_adr;
        logic [31:0] last_do;
        in_mem = 0; mem_len = 0; last_tx = -10; last_adr = '0; last_do = '0; cur = '0;
        forever begin
            @(negedge clk);
            if (!n_reset) begin
                in_mem   = 0;
                last_adr = bus.dbg_adr;
                last_do  = bus.dbg_do;
            end else begin
                if (bus.tx_start) begin
                    tx_count++;
                    check("tx_start_busy", bus.tx_busy, 1'b0);
                    check("tx_start_spacing", 32'((cyc - last_tx) > 1), 32'd1);
                    last_tx = cyc;
                    if (tx_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL tx_unexpected: got byte %h, expected no transmission", bus.tx_data);
                    end else begin
                        check("tx_data", bus.tx_data, tx_q.pop_front());
                    end
                end
                if (bus.dbg_mem_op) begin
                    if (!in_mem) begin
                        in_mem = 1; mem_len = 0; mem_count++;
                        if (mem_q.size() == 0) begin
                            checks++; fails++;
                            $display("FAIL mem_unexpected: got cycle at adr %h, expected no bus cycle", bus.dbg_adr);
                            cur = {bus.dbg_wren != 4'h0, bus.dbg_adr, bus.dbg_do};
                        end else begin
                            cur = mem_q.pop_front();
                        end
                    end
                    check("mem_adr", bus.dbg_adr, cur.adr);
                    check("mem_do", bus.dbg_do, cur.data);
                    check("mem_wren", bus.dbg_wren, cur.wr ? 4'hF : 4'h0);
                    mem_len++;
                end else begin
                    if (in_mem) begin
                        check("mem_cycles", mem_len, MEM_CYCLES);
                        in_mem = 0;
                    end
                    check("wren_idle", bus.dbg_wren, 4'h0);
                    check("adr_hold", bus.dbg_adr, last_adr);
                    check("do_hold", bus.dbg_do, last_do);
                end
                last_adr = bus.dbg_adr;
                last_do  = bus.dbg_do;
                check("cpu_n_reset", bus.cpu_n_reset, exp_cpu);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((tx_q.size() != 0 || mem_q.size() != 0) && waited < 2000) begin
            @(posedge clk);
            #1 waited++;
        end
        check("drain_done", 32'(tx_q.size() + mem_q.size()), 32'd0);
        tx_q.delete();
        mem_q.delete();
        idle(3);
    endtask

    // Command-level model: the whole command decides what the SoC side should see.
    task automatic run_cmd(input int n, input int gap, input bit junk);
        int need, tx0, mem0;
        logic [31:0] a, d;
        need = (cmd[0] == 8'h57) ? 9 : ((cmd[0] == 8'h52) ? 5 : 1);
        a = {cmd[4], cmd[3], cmd[2], cmd[1]};
        d = {cmd[8], cmd[7], cmd[6], cmd[5]};
        tx0 = tx_count; mem0 = mem_count;
        if (n >= need) begin
            if (cmd[0] == 8'h57) begin
                mem_q.push_back({1'b1, a, d});
                model_do = d;
                tx_q.push_back(8'h4B);
            end else if (cmd[0] == 8'h52) begin
                mem_q.push_back({1'b0, a, model_do});
                for (int i = 0; i < 4; i++) tx_q.push_back(rd_data[8*i +: 8]);
            end else if (cmd[0] == 8'h48 || cmd[0] == 8'h47) begin
                tx_q.push_back(8'h4B);
            end else begin
                tx_q.push_back(8'h3F);
            end
        end
        for (int i = 0; i < n && i < need; i++) begin
            if (i > 0) idle(gap);
            send_byte(cmd[i]);
            if (i == 0 && cmd[0] == 8'h48) exp_cpu = 1'b0;
            if (i == 0 && cmd[0] == 8'h47) exp_cpu = 1'b1;
        end
        if (junk) begin
            send_byte(8'h48);
            send_byte(8'h47);
            idle(2);
            send_byte(8'h48);
        end
        if (n < need) begin
            idle(TIMEOUT);
            check("abort_no_tx", tx_count, tx0);
            check("abort_no_mem", mem_count, mem0);
        end else begin
            drain();
        end
    endtask

    task automatic set_cmd(input logic [7:0] b0, input logic [31:0] a, input logic [31:0] d);
        cmd[0] = b0;
        for (int i = 0; i < 4; i++) begin
            cmd[1+i] = a[8*i +: 8];
            cmd[5+i] = d[8*i +: 8];
        end
    endtask

    initial begin : stimulus
        int sel, n, waited, tx0;
        logic [7:0] b;
        bus.rx_data = 8'd0; bus.rx_valid = 1'b0; bus.dbg_di = 32'd0;
        rd_data = 32'd0; model_do = 32'd0; exp_cpu = 1'b0;
        n_reset = 1'b1;
        #2 n_reset = 1'b0;
        #10;
        check("rst_tx_start", bus.tx_start, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_mem_op", bus.dbg_mem_op, 1'b0);
        check("rst_wren", bus.dbg_wren, 4'h0);
        check("rst_adr", bus.dbg_adr, 32'd0);
        check("rst_do", bus.dbg_do, 32'd0);
        check("rst_cpu_n_reset", bus.cpu_n_reset, 1'b0);
        @(posedge clk);
        #1 n_reset = 1'b1;
        idle(2);

        set_cmd(8'h57, 32'h0002_0000, 32'h0000_006F);
        run_cmd(9, 0, 1'b0);
        rd_data = 32'h1234_5678; bus.dbg_di = rd_data;
        set_cmd(8'h52, 32'h0002_0004, 32'd0);
        run_cmd(5, 1, 1'b1);
        set_cmd(8'h47, 32'd0, 32'd0); run_cmd(1, 0, 1'b0);
        set_cmd(8'h48, 32'd0, 32'd0); run_cmd(1, 0, 1'b0);
        set_cmd(8'hAA, 32'd0, 32'd0); run_cmd(1, 0, 1'b0);
        set_cmd(8'h57, 32'h0000_0201, 32'd0);
        run_cmd(3, 0, 1'b0);
        rd_data = 32'hCAFE_F00D; bus.dbg_di = rd_data;
        set_cmd(8'h52, 32'h0002_0000, 32'd0);
        run_cmd(5, 0, 1'b0);
        set_cmd(8'h57, 32'h1000_0040, 32'hA5A5_5A5A);
        run_cmd(9, TIMEOUT - 1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 2) begin
                set_cmd(8'h57, $urandom, $urandom);
                run_cmd(9, $urandom_range(0, 3), 1'b0);
            end else if (sel <= 4 || sel == 9) begin
                rd_data = $urandom; bus.dbg_di = rd_data;
                set_cmd(8'h52, $urandom, 32'd0);
                run_cmd(5, $urandom_range(0, 3), sel == 9);
            end else if (sel == 5) begin
                set_cmd(8'h48, 32'd0, 32'd0); run_cmd(1, 0, 1'b0);
            end else if (sel == 6) begin
                set_cmd(8'h47, 32'd0, 32'd0); run_cmd(1, 0, 1'b0);
            end else if (sel == 7) begin
                do b = 8'($urandom_range(0, 255));
                while (b == 8'h57 || b == 8'h52 || b == 8'h48 || b == 8'h47);
                set_cmd(b, 32'd0, 32'd0); run_cmd(1, 0, 1'b0);
            end else begin
                set_cmd(($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52, $urandom, $urandom);
                n = (cmd[0] == 8'h57) ? $urandom_range(1, 8) : $urandom_range(1, 4);
                run_cmd(n, $urandom_range(0, 3), 1'b0);
            end
        end

        set_cmd(8'h57, 32'h0000_1234, 32'hDEAD_BEEF);
        mem_q.push_back({1'b1, 32'h0000_1234, 32'hDEAD_BEEF});
        for (int i = 0; i < 9; i++) send_byte(cmd[i]);
        @(negedge clk);
        waited = 0;
        while (!bus.dbg_mem_op && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("mem_window_seen", bus.dbg_mem_op, 1'b1);
        #1 n_reset = 1'b0;
        exp_cpu = 1'b0;
        #1;
        check("reset_mid_mem_op", bus.dbg_mem_op, 1'b0);
        check("reset_mid_mem_wren", bus.dbg_wren, 4'h0);
        tx_q.delete();
        mem_q.delete();
        model_do = 32'd0;
        tx0 = tx_count;
        @(posedge clk);
        @(posedge clk);
        #1 n_reset = 1'b1;
        idle(30);
        check("reset_no_resp", tx_count, tx0);
        set_cmd(8'h48, 32'd0, 32'd0); run_cmd(1, 0, 1'b0);
        rd_data = 32'h0BAD_C0DE; bus.dbg_di = rd_data;
        set_cmd(8'h52, 32'h0000_0010, 32'd0); run_cmd(5, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
